// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - single-issue ALU micro-sequencer with 4x8 register file
module alu_sequencer #(
    parameter int         CNT_W    = 8,
    parameter logic [7:0] SAT_CODE = 8'hEE
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_instr_valid,
    input  logic [17:0]      i_instr,
    output logic             o_instr_ready,
    output logic [7:0]       o_alu_a,
    output logic [7:0]       o_alu_b,
    output logic [3:0]       o_alu_func,
    input  logic [7:0]       i_alu_result,
    output logic             o_done,
    output logic [7:0]       o_result,
    output logic             o_sat_err,
    input  logic             i_clr_err,
    input  logic [1:0]       i_rd_sel,
    output logic [7:0]       o_rd_data,
    output logic [CNT_W-1:0] o_instr_cnt,
    output logic             o_busy
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t     state;
    logic [7:0] r1, r2, r3;
    logic [1:0] rd_q;

    logic       imm_sel;
    logic [3:0] func;
    logic [1:0] rd, rs1, rs2;
    logic [7:0] imm;
    logic [7:0] rs1_val, rs2_val;
    logic       unused;

    assign imm_sel = i_instr[17];
    assign func    = i_instr[16:13];
    assign rd      = i_instr[12:11];
    assign rs1     = i_instr[10:9];
    assign imm     = i_instr[7:0];
    assign rs2     = i_instr[1:0];
    assign unused  = i_instr[8];

    // R0 is hardwired to zero; no storage exists for it
    function automatic logic [7:0] rf_read(input logic [1:0] sel,
                                           input logic [7:0] v1,
                                           input logic [7:0] v2,
                                           input logic [7:0] v3);
        case (sel)
            2'd1:    rf_read = v1;
            2'd2:    rf_read = v2;
            2'd3:    rf_read = v3;
            default: rf_read = 8'h00;
        endcase
    endfunction

    assign rs1_val   = rf_read(rs1, r1, r2, r3);
    assign rs2_val   = rf_read(rs2, r1, r2, r3);
    assign o_rd_data = rf_read(i_rd_sel, r1, r2, r3);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            r1            <= 8'h00;
            r2            <= 8'h00;
            r3            <= 8'h00;
            rd_q          <= 2'd0;
            o_alu_a       <= 8'h00;
            o_alu_b       <= 8'h00;
            o_alu_func    <= 4'h0;
            o_done        <= 1'b0;
            o_result      <= 8'h00;
            o_sat_err     <= 1'b0;
            o_instr_cnt   <= '0;
            o_instr_ready <= 1'b1;
            o_busy        <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_clr_err)
                o_sat_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_instr_valid && o_instr_ready) begin
                        o_alu_a       <= rs1_val;
                        o_alu_b       <= imm_sel ? imm : rs2_val;
                        o_alu_func    <= func;
                        rd_q          <= rd;
                        o_instr_ready <= 1'b0;
                        o_busy        <= 1'b1;
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    state <= WB;
                end
                WB: begin
                    case (rd_q)
                        2'd1:    r1 <= i_alu_result;
                        2'd2:    r2 <= i_alu_result;
                        2'd3:    r3 <= i_alu_result;
                        default: ;
                    endcase
                    o_result      <= i_alu_result;
                    o_done        <= 1'b1;
                    o_instr_cnt   <= o_instr_cnt + CNT_W'(1);
                    o_instr_ready <= 1'b1;
                    o_busy        <= 1'b0;
                    state         <= IDLE;
                    // Placed after the clear so a coincident set takes priority
                    if ((o_alu_func == 4'b0010 || o_alu_func == 4'b0011) &&
                        i_alu_result == SAT_CODE)
                        o_sat_err <= 1'b1;
                end
                default: begin
                    o_instr_ready <= 1'b1;
                    o_busy        <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule
